// File: rtl/lsr_seq16.sv
// rtl/lsr_seq16.sv - sequential 16-bit logical/arithmetic right shifter, one bit per clock
module lsr_seq16 #(
    parameter int WIDTH      = 16,
    parameter int SHAMT_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inp,
    input  logic [15:0]      shift_value,
    input  logic             arith,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [WIDTH-1:0]      r_acc;
    logic [SHAMT_BITS-1:0] r_cnt;
    logic                  r_mode;
    logic [WIDTH-1:0]      r_out;
    logic                  r_done;

    logic                  w_load;
    logic                  w_step;
    logic                  w_finish;
    logic                  w_fill;
    logic [WIDTH-1:0]      w_acc_shifted;
    logic [SHAMT_BITS-1:0] w_cnt_dec;

    // Only the low shift_value bits select an amount; the rest are don't-care.
    logic                  w_unused;
    assign w_unused = ^shift_value[15:SHAMT_BITS];

    // Sign fill comes from the live accumulator MSB, which equals the
    // original sign bit because every arithmetic step re-copies it.
    assign w_fill        = r_mode & r_acc[WIDTH-1];
    assign w_acc_shifted = {w_fill, r_acc[WIDTH-1:1]};
    assign w_cnt_dec     = r_cnt - {{(SHAMT_BITS-1){1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_step = 1'b1;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Working registers: capture on accept, shift one bit per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_mode <= 1'b0;
        end else if (w_load) begin
            r_acc  <= inp;
            r_cnt  <= shift_value[SHAMT_BITS-1:0];
            r_mode <= arith;
        end else if (w_step) begin
            r_acc  <= w_acc_shifted;
            r_cnt  <= w_cnt_dec;
        end
    end

    // Result register and completion pulse; out only moves on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_out <= r_acc;
            end
        end
    end

    assign out  = r_out;
    assign done = r_done;
    assign busy = (r_state == S_SHIFT);

endmodule

// File: tb/tb_lsr_seq16.sv
// tb/tb_lsr_seq16.sv - scoreboard testbench for lsr_seq16
module tb_lsr_seq16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] inp;
    logic [15:0] shift_value;
    logic        arith;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int n_tests;
    int n_fail;
    int cyc;

    typedef struct {
        logic [15:0] out;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    lsr_seq16 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .inp         (inp),
        .shift_value (shift_value),
        .arith       (arith),
        .out         (out),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] n, input logic m);
        logic [15:0] r;
        r = a;
        for (int i = 0; i < 16; i++) begin
            if (i < n) r = {m & r[15], r[15:1]};
        end
        return r;
    endfunction

    // Scoreboard: every completion pops the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("out", {16'd0, out}, {16'd0, e.out});
                check_eq("done_cycle", cyc, e.cyc);
                check_eq("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Called at a negedge: drive start for one edge and record expectation.
    task automatic issue(input logic [15:0] a, input logic [15:0] sv, input logic m,
                         input logic [15:0] exp_out);
        exp_t e;
        inp         = a;
        shift_value = sv;
        arith       = m;
        start       = 1'b1;
        e.out       = exp_out;
        e.cyc       = cyc + int'(sv[3:0]) + 2;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!done) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] sv;
        logic        m;
        logic [15:0] held;
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        rst         = 1'b0;
        start       = 1'b0;
        inp         = '0;
        shift_value = '0;
        arith       = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset_out", {16'd0, out}, 32'd0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(16'hB000, 16'd1, 1'b0, 16'h5800);
        wait_done();
        @(negedge clk);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);

        issue(16'hFF80, 16'd3, 1'b1, 16'hFFF0);
        wait_done();
        @(negedge clk);
        issue(16'hFF80, 16'd3, 1'b0, 16'h1FF0);
        wait_done();
        @(negedge clk);
        issue(16'h8001, 16'd15, 1'b0, 16'h0001);
        wait_done();
        @(negedge clk);
        issue(16'h8000, 16'd15, 1'b1, 16'hFFFF);
        wait_done();
        @(negedge clk);
        issue(16'h000B, 16'd0, 1'b0, 16'h000B);
        wait_done();
        @(negedge clk);
        issue(16'h000B, 16'h0011, 1'b0, 16'h0005);
        wait_done();

        // Idle hold: out stays put, no done.
        @(negedge clk);
        held = out;
        repeat (3) @(negedge clk);
        check_eq("idle_hold_out", {16'd0, out}, {16'd0, held});
        check_eq("idle_hold_done", {31'd0, done}, 32'd0);

        // start during busy is ignored; then back-to-back in the done cycle.
        issue(16'h1234, 16'd6, 1'b0, 16'h0048);
        start       = 1'b1;
        inp         = 16'hFFFF;
        shift_value = 16'd0;
        arith       = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done();
        issue(16'h0F00, 16'd4, 1'b0, 16'h00F0);
        wait_done();
        @(negedge clk);

        // Random operations against the model.
        for (int i = 0; i < 8; i++) begin
            a  = 16'($urandom);
            sv = 16'($urandom);
            m  = 1'($urandom_range(0, 1));
            issue(a, sv, m, model(a, sv[3:0], m));
            wait_done();
            @(negedge clk);
        end

        // Reset mid-operation aborts with no later done.
        issue(16'hFFFF, 16'd10, 1'b0, 16'h003F);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        sb.delete();
        check_eq("abort_out", {16'd0, out}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("post_abort_busy", {31'd0, busy}, 32'd0);
        check_eq("post_abort_out", {16'd0, out}, 32'd0);

        issue(16'hC3C3, 16'd2, 1'b1, 16'hF0F0);
        wait_done();
        repeat (2) @(negedge clk);
        check_eq("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
